// File: rtl/ram_row_loader.sv
// Packs a stream of feature/y words into RAM rows and writes them to RAM2.
// Ports: CLK/RST, start+num_rows, in_word/in_valid/in_ready, RAM bus, status.
module ram_row_loader #(
  parameter int ADDR_WIDTH   = 4,
  parameter int MAX_FEATURES = 6,
  parameter int WORD_WIDTH   = 16,
  parameter int DATA_WIDTH   = WORD_WIDTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bus_own,
  output logic                  we,
  output logic                  oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   rows_done,
  output logic                  done
);

  localparam int CW = $clog2(MAX_FEATURES + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_FEATURES);
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   nrows_q, nrows_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rows_done_q, rows_done_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic                  bus_own_q, bus_own_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   clamped;

  always_comb begin
    state_d     = state_q;
    nrows_d     = nrows_q;
    addr_d      = addr_q;
    rows_done_d = rows_done_q;
    wcnt_d      = wcnt_q;
    data_out_d  = data_out_q;
    clamped     = (num_rows > CAP) ? CAP : num_rows;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nrows_d     = clamped;
          addr_d      = '0;
          rows_done_d = '0;
          wcnt_d      = '0;
          state_d     = (clamped == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          for (int k = 0; k <= MAX_FEATURES; k++) begin
            if (wcnt_q == CW'(k)) begin
              data_out_d[WORD_WIDTH*k +: WORD_WIDTH] = in_word;
            end
          end
          if (wcnt_q == LAST) begin
            state_d = WRITE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // addr wraps naturally to 0 after the last row of a full RAM
        addr_d      = addr_q + 1'b1;
        rows_done_d = rows_done_q + 1'b1;
        wcnt_d      = '0;
        state_d     = (rows_done_d == nrows_q) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered copies of what the next state implies
    in_ready_d = (state_d == COLLECT);
    we_d       = (state_d == WRITE);
    bus_own_d  = (state_d == COLLECT) || (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      nrows_q     <= '0;
      addr_q      <= '0;
      rows_done_q <= '0;
      wcnt_q      <= '0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      bus_own_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrows_q     <= nrows_d;
      addr_q      <= addr_d;
      rows_done_q <= rows_done_d;
      wcnt_q      <= wcnt_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      bus_own_q   <= bus_own_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bus_own   = bus_own_q;
  assign we        = we_q;
  assign oe        = 1'b0;
  assign addr      = addr_q;
  assign data_out  = data_out_q;
  assign rows_done = rows_done_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_row_loader.sv
// Directed self-checking bench for ram_row_loader.
// Ports: drives start/num_rows/stream, checks RAM bus and status outputs.
module tb_ram_row_loader;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   num_rows = '0;
  logic [15:0]  in_word = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, bus_own, we, oe, done;
  logic [3:0]   addr;
  logic [111:0] data_out;
  logic [4:0]   rows_done;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0]   log_addr [0:63];
  logic [111:0] log_data [0:63];
  int           wr_cnt = 0;

  ram_row_loader dut (
    .CLK(CLK), .RST(RST), .start(start), .num_rows(num_rows),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .bus_own(bus_own), .we(we), .oe(oe), .addr(addr),
    .data_out(data_out), .rows_done(rows_done), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (we === 1'b1 && wr_cnt < 64) begin
      log_addr[wr_cnt] = addr;
      log_data[wr_cnt] = data_out;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] pack(input logic [15:0] b);
    logic [111:0] r;
    for (int k = 0; k < 7; k++) r[16*k +: 16] = b + 16'(k);
    return r;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic stream(input int n, input logic [15:0] base,
                        input bit toggle);
    int j = 0;
    int g = 0;
    logic hs;
    while (j < n && g < 2000) begin
      in_valid = 1'b1;
      in_word = base + 16'(j);
      hs = in_ready;
      cyc();
      if (hs) begin
        j++;
        if (toggle) begin
          in_valid = 1'b0;
          in_word = 16'hdead;
          cyc();
        end
      end
      g++;
    end
    in_valid = 1'b0;
    chk("stream_budget", 128'(j), 128'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 100) begin
      cyc();
      g++;
    end
    chk("done_budget", 128'(done), 128'd1);
  endtask

  task automatic go(input logic [4:0] n);
    start = 1'b1;
    num_rows = n;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int b;
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_we", 128'(we), 128'd0);
    chk("rst_addr", 128'(addr), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_data", 128'(data_out), 128'd0);
    RST = 1'b0;
    cyc();

    // 1: one row, back-to-back words 1..7
    b = wr_cnt;
    go(5'd1);
    chk("t1_bus_own", 128'(bus_own), 128'd1);
    chk("t1_in_ready", 128'(in_ready), 128'd1);
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_word = 16'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t1_we", 128'(we), 128'd1);
    chk("t1_oe", 128'(oe), 128'd0);
    chk("t1_ready_low", 128'(in_ready), 128'd0);
    chk("t1_addr", 128'(addr), 128'd0);
    chk("t1_data", 128'(data_out),
        128'h0007_0006_0005_0004_0003_0002_0001);
    chk("t1_done_early", 128'(done), 128'd0);
    cyc();
    chk("t1_done", 128'(done), 128'd1);
    chk("t1_rows_done", 128'(rows_done), 128'd1);
    chk("t1_bus_rel", 128'(bus_own), 128'd0);
    chk("t1_nwr", 128'(wr_cnt - b), 128'd1);

    // 2: three rows with in_valid toggling
    b = wr_cnt;
    go(5'd3);
    stream(21, 16'h0200, 1'b1);
    wait_done();
    chk("t2_nwr", 128'(wr_cnt - b), 128'd3);
    for (int r = 0; r < 3; r++) begin
      chk("t2_waddr", 128'(log_addr[b+r]), 128'(r));
      chk("t2_wdata", 128'(log_data[b+r]), 128'(pack(16'h0200 + 16'(7*r))));
    end
    chk("t2_addr", 128'(addr), 128'd3);
    chk("t2_rows_done", 128'(rows_done), 128'd3);

    // 3: zero rows
    b = wr_cnt;
    go(5'd0);
    chk("t3_done", 128'(done), 128'd1);
    chk("t3_rows_done", 128'(rows_done), 128'd0);
    cyc();
    chk("t3_nwr", 128'(wr_cnt - b), 128'd0);

    // 4: 20 requested, clamped to 16
    b = wr_cnt;
    go(5'd20);
    stream(112, 16'h1000, 1'b0);
    wait_done();
    chk("t4_nwr", 128'(wr_cnt - b), 128'd16);
    for (int r = 0; r < 16; r++) begin
      chk("t4_waddr", 128'(log_addr[b+r]), 128'(r));
      chk("t4_wdata", 128'(log_data[b+r]), 128'(pack(16'h1000 + 16'(7*r))));
    end
    chk("t4_addr_wrap", 128'(addr), 128'd0);
    chk("t4_rows_done", 128'(rows_done), 128'd16);
    cyc();
    chk("t4_no_extra", 128'(wr_cnt - b), 128'd16);

    // 5: reset after 3 words of row 2
    go(5'd4);
    stream(17, 16'h0500, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("t5_we", 128'(we), 128'd0);
    chk("t5_in_ready", 128'(in_ready), 128'd0);
    chk("t5_bus_own", 128'(bus_own), 128'd0);
    chk("t5_addr", 128'(addr), 128'd0);
    chk("t5_rows_done", 128'(rows_done), 128'd0);
    chk("t5_data", 128'(data_out), 128'd0);
    #1;
    RST = 1'b0;
    cyc();
    b = wr_cnt;
    go(5'd1);
    stream(7, 16'h0a00, 1'b0);
    wait_done();
    chk("t5_nwr", 128'(wr_cnt - b), 128'd1);
    chk("t5_waddr", 128'(log_addr[b]), 128'd0);
    chk("t5_wdata", 128'(log_data[b]), 128'(pack(16'h0a00)));

    // 6: start ignored in COLLECT and WRITE, honoured in DONE
    b = wr_cnt;
    go(5'd2);
    stream(3, 16'h0600, 1'b0);
    start = 1'b1;
    num_rows = 5'd5;
    cyc();
    start = 1'b0;
    chk("t6_col_ready", 128'(in_ready), 128'd1);
    chk("t6_col_done", 128'(done), 128'd0);
    stream(4, 16'h0603, 1'b0);
    chk("t6_in_write", 128'(we), 128'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_wr_addr", 128'(addr), 128'd1);
    chk("t6_wr_rows", 128'(rows_done), 128'd1);
    chk("t6_wr_ready", 128'(in_ready), 128'd1);
    stream(7, 16'h060a, 1'b0);
    wait_done();
    chk("t6_rows_done", 128'(rows_done), 128'd2);
    chk("t6_nwr", 128'(wr_cnt - b), 128'd2);
    chk("t6_wdata0", 128'(log_data[b]), 128'(pack(16'h0600)));
    chk("t6_wdata1", 128'(log_data[b+1]), 128'(pack(16'h060a)));
    b = wr_cnt;
    go(5'd1);
    chk("t6_re_done", 128'(done), 128'd0);
    chk("t6_re_addr", 128'(addr), 128'd0);
    chk("t6_re_rows", 128'(rows_done), 128'd0);
    chk("t6_re_bus", 128'(bus_own), 128'd1);
    chk("t6_re_ready", 128'(in_ready), 128'd1);
    stream(7, 16'h0700, 1'b0);
    wait_done();
    chk("t6_re_nwr", 128'(wr_cnt - b), 128'd1);
    chk("t6_re_waddr", 128'(log_addr[b]), 128'd0);
    chk("t6_re_wdata", 128'(log_data[b]), 128'(pack(16'h0700)));
    chk("oe_low", 128'(oe), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
